// File: rtl/aes_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : aes_sched_pkg                                              |
// | Brief   : Shared types and constants for the AES round scheduler:    |
// |           FSM state encoding, key-size codes and round counts.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package aes_sched_pkg;

  // Scheduler states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Key-size codes as presented on req_ksize
  localparam logic [1:0] KS_128 = 2'd0;
  localparam logic [1:0] KS_192 = 2'd1;
  localparam logic [1:0] KS_256 = 2'd2;
  localparam logic [1:0] KS_INV = 2'd3;

  // Number of cipher rounds per key size
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Round count for a (valid) key-size code
  function automatic logic [3:0] nr_of(input logic [1:0] ks);
    case (ks)
      KS_192:  nr_of = NR_192;
      KS_256:  nr_of = NR_256;
      default: nr_of = NR_128;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_scheduler_rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_arbiter2                                                |
// | Brief   : Two-input round-robin arbiter. On a tie the pointer-       |
// |           preferred input wins; after any accept the pointer moves   |
// |           to the input that did not win.                             |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic ptr_q;

  // One-hot grant; zero when disabled or nobody is requesting
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        grant_o = ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant_o = req_i;
      end
    end
  end

  // Pointer hands priority to the loser once a grant is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (accept_i) begin
      ptr_q <= ~grant_o[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_round_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : aes_round_scheduler                                        |
// | Brief   : Arbitrates AES jobs from two requesters onto one shared    |
// |           round engine and sequences load / rounds / final round.    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module aes_round_scheduler
  import aes_sched_pkg::*;
#(
  parameter int NUM_REQ = 2  // only 2 is supported
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_ksize,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 abort,
  input  logic                 eng_rdy,
  output logic                 eng_load,
  output logic                 eng_step,
  output logic                 eng_final,
  output logic [3:0]           eng_round,
  output logic                 eng_sel,
  output logic [1:0]           eng_ksize,
  output logic                 done,
  output logic                 done_id,
  output logic                 err,
  output logic                 err_id,
  output logic                 busy
);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       owner_q, owner_d;
  logic [1:0] ksize_q, ksize_d;
  logic       err_q, err_d;
  logic       err_id_q, err_id_d;

  logic       w_arb_en;
  logic       w_accept;
  logic       w_win_id;
  logic [1:0] w_acc_ksize;
  logic [3:0] w_nr;

  // Grants are only offered in IDLE and never while reset is held,
  // so req_ready reads zero during reset as every other output does.
  assign w_arb_en    = (state_q == ST_IDLE) && !reset;
  assign w_accept    = |(req_valid & req_ready);
  assign w_win_id    = req_ready[1];
  assign w_acc_ksize = w_win_id ? req_ksize[3:2] : req_ksize[1:0];
  assign w_nr        = nr_of(ksize_q);

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .en_i     (w_arb_en),
    .req_i    (req_valid),
    .accept_i (w_accept),
    .grant_o  (req_ready)
  );

  // State and job-context registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      round_q  <= 4'd0;
      owner_q  <= 1'b0;
      ksize_q  <= KS_128;
      err_q    <= 1'b0;
      err_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      owner_q  <= owner_d;
      ksize_q  <= ksize_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  // Next-state logic and engine command decode
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    owner_d   = owner_q;
    ksize_d   = ksize_q;
    err_d     = 1'b0;
    err_id_d  = 1'b0;
    eng_load  = 1'b0;
    eng_step  = 1'b0;
    eng_final = 1'b0;
    eng_round = 4'd0;
    done      = 1'b0;
    done_id   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        round_d = 4'd0;
        if (w_accept) begin
          if (w_acc_ksize == KS_INV) begin
            // Rejected job: flag it, stay idle, issue nothing
            err_d    = 1'b1;
            err_id_d = w_win_id;
          end else begin
            owner_d = w_win_id;
            ksize_d = w_acc_ksize;
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        eng_load  = 1'b1;
        eng_round = round_q;
        if (abort) begin
          state_d = ST_IDLE;
          round_d = 4'd0;
        end else if (eng_rdy) begin
          state_d = ST_ROUND;
          round_d = 4'd1;
        end
      end

      ST_ROUND: begin
        eng_step  = 1'b1;
        eng_round = round_q;
        if (abort) begin
          state_d = ST_IDLE;
          round_d = 4'd0;
        end else if (eng_rdy) begin
          // Counter runs straight on to Nr so FINAL can present it as-is
          round_d = round_q + 4'd1;
          if (round_q == (w_nr - 4'd1)) begin
            state_d = ST_FINAL;
          end
        end
      end

      ST_FINAL: begin
        eng_step  = 1'b1;
        eng_final = 1'b1;
        eng_round = round_q;
        if (abort) begin
          state_d = ST_IDLE;
          round_d = 4'd0;
        end else if (eng_rdy) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        done_id = owner_q;
        state_d = ST_IDLE;
        round_d = 4'd0;
      end

      default: begin
        state_d = ST_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign eng_sel   = busy ? owner_q : 1'b0;
  assign eng_ksize = busy ? ksize_q : 2'b00;
  assign err       = err_q;
  assign err_id    = err_id_q;

endmodule
`default_nettype wire
